// File: rtl/lcd_display_scheduler.sv
// lcd_display_scheduler
// Time-shares the 64-bit LCD display word between four requesters using a
// round-robin dwell scheduler, with a manual force override that pins the
// display to one source. All outputs are registered; a grant decided on an
// edge updates the shown index, the shown word and the pulses on that edge.
module lcd_display_scheduler #(
    parameter int DWELL_CYCLES = 100000000,
    parameter int TW           = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   src_valid,
    input  logic [255:0] src_data,
    input  logic         force_en,
    input  logic [1:0]   force_sel,
    output logic [63:0]  disp_data,
    output logic [1:0]   disp_src,
    output logic         disp_update,
    output logic [3:0]   src_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);

    // Round-robin search: first set bit of req starting at ptr+1 and wrapping.
    // Result is {found, index}. Iterating from the farthest candidate down to
    // ptr+1 lets the nearest candidate overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k + 1);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Select one 64-bit source word out of the packed source bus.
    function automatic logic [63:0] word_of(input logic [255:0] data, input logic [1:0] idx);
        return data[{idx, 6'd0} +: 64];
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [63:0]   disp_data_q, disp_data_d;
    logic [1:0]    disp_src_q, disp_src_d;
    logic          disp_update_q, disp_update_d;
    logic [3:0]    src_ack_q, src_ack_d;

    logic          cur_valid;
    logic [3:0]    other_valid;
    logic [2:0]    pick_any;
    logic [2:0]    pick_other;
    logic          do_grant;
    logic [1:0]    grant_idx;
    logic          do_force;

    // Candidate selection shared by IDLE grants, dwell expiry and force release.
    // In SHOW and FORCE rr_ptr always equals the shown index, so searching the
    // other sources from rr_ptr+1 visits them in round-robin order.
    always_comb begin
        cur_valid   = src_valid[disp_src_q];
        other_valid = src_valid & ~(4'b0001 << disp_src_q);
        pick_any    = rr_pick(src_valid, rr_ptr_q);
        pick_other  = rr_pick(other_valid, rr_ptr_q);
    end

    // Next-state and output decode; force and grant actions are applied after
    // the per-state decision so every path updates the registers the same way.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        disp_data_d   = disp_data_q;
        disp_src_d    = disp_src_q;
        disp_update_d = 1'b0;
        src_ack_d     = 4'b0000;
        do_grant      = 1'b0;
        grant_idx     = pick_any[1:0];
        do_force      = 1'b0;

        case (state_q)
            IDLE: begin
                // Force has priority over a pending grant.
                if (force_en) begin
                    do_force = 1'b1;
                end else if (pick_any[2]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_any[1:0];
                end
            end

            SHOW: begin
                if (force_en) begin
                    do_force = 1'b1;
                end else if (timer_q == DWELL_LAST) begin
                    if (pick_other[2]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_other[1:0];
                    end else if (cur_valid) begin
                        // Sole requester keeps the display silently.
                        timer_d     = '0;
                        disp_data_d = word_of(src_data, disp_src_q);
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else begin
                    // A source that drops mid-dwell keeps the display (frozen
                    // word) until expiry.
                    timer_d = timer_q + TW'(1);
                    if (cur_valid) begin
                        disp_data_d = word_of(src_data, disp_src_q);
                    end
                end
            end

            FORCE: begin
                if (force_en) begin
                    do_force = 1'b1;
                end else if (cur_valid) begin
                    state_d     = SHOW;
                    timer_d     = '0;
                    disp_data_d = word_of(src_data, disp_src_q);
                end else if (pick_other[2]) begin
                    // Release onto an invalid source behaves like an expiry.
                    do_grant  = 1'b1;
                    grant_idx = pick_other[1:0];
                end else begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (do_force) begin
            state_d       = FORCE;
            timer_d       = '0;
            rr_ptr_d      = force_sel;
            disp_src_d    = force_sel;
            disp_data_d   = word_of(src_data, force_sel);
            disp_update_d = (force_sel != disp_src_q);
        end

        if (do_grant) begin
            state_d       = SHOW;
            timer_d       = '0;
            rr_ptr_d      = grant_idx;
            disp_src_d    = grant_idx;
            disp_data_d   = word_of(src_data, grant_idx);
            src_ack_d     = 4'b0001 << grant_idx;
            disp_update_d = (grant_idx != disp_src_q);
        end
    end

    // State, timer, pointer and output registers; reset is asynchronous so a
    // mid-dwell reset clears the display without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rr_ptr_q      <= 2'd3;
            disp_data_q   <= '0;
            disp_src_q    <= 2'd0;
            disp_update_q <= 1'b0;
            src_ack_q     <= 4'b0000;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rr_ptr_q      <= rr_ptr_d;
            disp_data_q   <= disp_data_d;
            disp_src_q    <= disp_src_d;
            disp_update_q <= disp_update_d;
            src_ack_q     <= src_ack_d;
        end
    end

    assign disp_data   = disp_data_q;
    assign disp_src    = disp_src_q;
    assign disp_update = disp_update_q;
    assign src_ack     = src_ack_q;

endmodule

// File: tb/tb_lcd_display_scheduler.sv
// Testbench for lcd_display_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the scheduler.
module tb_lcd_display_scheduler;

    localparam int DWELL = 8;

    localparam int M_IDLE  = 0;
    localparam int M_SHOW  = 1;
    localparam int M_FORCE = 2;

    logic         clk;
    logic         rst;
    logic [3:0]   src_valid;
    logic [255:0] src_data;
    logic         force_en;
    logic [1:0]   force_sel;
    logic [63:0]  disp_data;
    logic [1:0]   disp_src;
    logic         disp_update;
    logic [3:0]   src_ack;

    int errors;
    int checks;

    // Behavioural model state
    int          m_mode;
    int          m_src;
    int          m_ptr;
    int          m_cnt;
    logic [63:0] m_data;
    logic        m_upd;
    logic [3:0]  m_ack;

    lcd_display_scheduler #(
        .DWELL_CYCLES(DWELL),
        .TW(27)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_valid(src_valid),
        .src_data(src_data),
        .force_en(force_en),
        .force_sel(force_sel),
        .disp_data(disp_data),
        .disp_src(disp_src),
        .disp_update(disp_update),
        .src_ack(src_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] word(input int i);
        return src_data[64*i +: 64];
    endfunction

    // First index in mask after 'from', going around; -1 if mask is empty.
    function automatic int next_valid(input logic [3:0] mask, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_src  = 0;
        m_ptr  = 3;
        m_cnt  = 0;
        m_data = '0;
        m_upd  = 1'b0;
        m_ack  = 4'b0000;
    endtask

    task automatic model_grant(input int g);
        m_ack  = 4'b0001 << g;
        m_upd  = (g != m_src);
        m_src  = g;
        m_ptr  = g;
        m_data = word(g);
        m_cnt  = 0;
        m_mode = M_SHOW;
    endtask

    task automatic model_force();
        m_upd  = (int'(force_sel) != m_src);
        m_src  = int'(force_sel);
        m_ptr  = m_src;
        m_data = word(m_src);
        m_cnt  = 0;
        m_mode = M_FORCE;
    endtask

    // One clock edge of the intended behaviour, from the inputs seen at that edge.
    task automatic model_step();
        logic [3:0] others;
        int g;
        if (!rst) begin
            model_reset();
            return;
        end
        m_upd  = 1'b0;
        m_ack  = 4'b0000;
        others = src_valid;
        others[m_src] = 1'b0;
        if (m_mode != M_FORCE && force_en) begin
            model_force();
        end else if (m_mode == M_IDLE) begin
            g = next_valid(src_valid, m_ptr);
            if (g >= 0) model_grant(g);
        end else if (m_mode == M_SHOW) begin
            if (m_cnt == DWELL - 1) begin
                g = next_valid(others, m_ptr);
                if (g >= 0) model_grant(g);
                else if (src_valid[m_src]) begin
                    m_cnt  = 0;
                    m_data = word(m_src);
                end else begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
                if (src_valid[m_src]) m_data = word(m_src);
            end
        end else begin
            if (force_en) model_force();
            else if (src_valid[m_src]) begin
                m_mode = M_SHOW;
                m_cnt  = 0;
                m_data = word(m_src);
            end else begin
                g = next_valid(others, m_ptr);
                if (g >= 0) model_grant(g);
                else begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("disp_data", disp_data, m_data);
        chk("disp_src", 64'(disp_src), 64'(m_src));
        chk("disp_update", 64'(disp_update), 64'(m_upd));
        chk("src_ack", 64'(src_ack), 64'(m_ack));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        int n;
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        src_valid = 4'b0000;
        src_data  = '0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        model_reset();
        #3;
        check_outputs();
        cycle();
        cycle();

        // Two sources alternate every dwell period
        src_data  = {64'h4444_4444_4444_4444, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h1111_1111_1111_1111};
        src_valid = 4'b0101;
        rst = 1'b1;
        cycle();
        chk("t1_first_ack", 64'(src_ack), 64'h1);
        chk("t1_first_data", disp_data, 64'h1111_1111_1111_1111);
        for (int i = 0; i < 8; i++) cycle();
        chk("t1_second_ack", 64'(src_ack), 64'h4);
        chk("t1_second_upd", 64'(disp_update), 64'h1);
        chk("t1_second_src", 64'(disp_src), 64'h2);
        for (int i = 0; i < 8; i++) cycle();
        chk("t1_back_src", 64'(disp_src), 64'h0);

        // Single live source with changing content
        src_valid = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            src_data[64*1 +: 64] = {$urandom, $urandom};
            cycle();
        end

        // Sources vanish mid-dwell, then source 3 appears
        src_valid = 4'b0001;
        n = 0;
        while (!(m_mode == M_SHOW && m_src == 0 && m_cnt == 2) && n < 40) begin
            cycle();
            n++;
        end
        chk("t3_sync", 64'(n < 40), 64'h1);
        src_valid = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            src_data[64*0 +: 64] = {$urandom, $urandom};
            cycle();
        end
        src_valid = 4'b1000;
        cycle();
        chk("t3_ack3", 64'(src_ack), 64'h8);
        cycle();

        // Force onto an invalid source, then release
        src_valid = 4'b0001;
        n = 0;
        while (!(m_mode == M_SHOW && m_src == 0) && n < 40) begin
            cycle();
            n++;
        end
        chk("t4_sync", 64'(n < 40), 64'h1);
        force_en  = 1'b1;
        force_sel = 2'd3;
        for (int i = 0; i < 20; i++) begin
            src_data[64*3 +: 64] = {$urandom, $urandom};
            cycle();
        end
        chk("t4_force_src", 64'(disp_src), 64'h3);
        force_en = 1'b0;
        cycle();
        chk("t4_release_ack", 64'(src_ack), 64'h1);
        cycle();

        // Force arriving exactly on dwell expiry
        src_valid = 4'b0011;
        n = 0;
        while (!(m_mode == M_SHOW && m_cnt == DWELL - 1) && n < 40) begin
            cycle();
            n++;
        end
        chk("t5_sync", 64'(n < 40), 64'h1);
        force_en  = 1'b1;
        force_sel = 2'($urandom_range(0, 3));
        cycle();
        chk("t5_no_ack", 64'(src_ack), 64'h0);
        for (int i = 0; i < 4; i++) cycle();
        force_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset between edges
        src_valid = 4'b0101;
        n = 0;
        while (!(m_mode == M_SHOW && m_cnt == 3) && n < 40) begin
            cycle();
            n++;
        end
        chk("t6_sync", 64'(n < 40), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        rst = 1'b1;
        cycle();
        chk("t6_regrant0", 64'(src_ack), 64'h1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int j = 0; j < 4; j++) src_data[64*j +: 64] = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) src_valid = 4'($urandom);
            if ($urandom_range(0, 19) == 0) force_en = ~force_en;
            if ($urandom_range(0, 7) == 0) force_sel = 2'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_display_scheduler.md
Name: lcd_display_scheduler

Overview:
Time-shares the single 64-bit LCD display word between four on-chip requesters, such as PC, instruction, register-file debug port and status. It uses a round-robin dwell scheduler with a manual force override. Its output feeds the LCD driver's 64-bit data input and is stable except at defined update points. It sits between the core debug taps and the LCD driver in the top level.

Parameters:
DWELL_CYCLES, 100000000, cycles each source is shown before rotation (2 s at 50 MHz); legal range 2..2^27-1
TW, 27, dwell timer width; must hold DWELL_CYCLES-1

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
src_valid  in  4  source i has content to display
src_data  in  256  source i word on [64i+63:64i]
force_en  in  1  manual override active
force_sel  in  2  source index shown while force_en=1
disp_data  out  64  word to LCD driver data input
disp_src  out  2  index of source currently shown
disp_update  out  1  1-cycle pulse when disp_src changes
src_ack  out  4  one-hot 1-cycle pulse: source i granted the display

Behaviour:
- Reset (rst=0, async): state=IDLE, disp_data=0, disp_src=0, disp_update=0, src_ack=0, timer=0, rr_ptr=3 (source 0 has first priority).
- All outputs are registered. A grant decided on an edge updates disp_src, disp_data (from the new source), src_ack and disp_update on that same edge.
- Round-robin pick: the first valid index searching rr_ptr+1, rr_ptr+2, ... mod 4. rr_ptr becomes the granted index.
- States: IDLE, SHOW, FORCE.
- IDLE:
  - disp_data holds its last value.
  - Any src_valid -> grant the picked source, timer=0, go to SHOW.
  - force_en -> FORCE (priority over grant).
- SHOW:
  - While src_valid[disp_src]=1, disp_data <= src_data[disp_src] every cycle (live refresh). Otherwise disp_data is held.
  - Timer increments each cycle.
  - When timer==DWELL_CYCLES-1:
    - another valid source exists -> grant the next RR source, timer=0;
    - only the current source is valid -> timer=0, stay, no ack/update pulse;
    - none valid -> IDLE.
  - If src_valid[disp_src] drops before expiry, the current source is kept until expiry (no early switch).
- FORCE:
  - Entry: disp_src=force_sel, timer=0, disp_update pulses if the index changed. No src_ack pulse.
  - disp_data <= src_data[force_sel] every cycle regardless of src_valid.
  - A force_sel change while in FORCE updates disp_src on the next edge and pulses disp_update.
  - rr_ptr <= force_sel.
  - Timer held at 0.
  - force_en=0 -> SHOW with timer=0 on the same source if src_valid[disp_src]=1. Otherwise it is treated as a SHOW expiry with that source invalid on the same edge: grant the next RR source if any valid, else IDLE.
- Simultaneous events:
  - force_en beats dwell expiry and IDLE grant.
  - Dwell expiry with a source asserting valid on the same cycle: that source is eligible.
- Grant rules:
  - A grant to a different index pulses both src_ack and disp_update.
  - A grant to the same index (e.g. from IDLE) pulses src_ack only.
- Reset mid-operation returns to the reset values immediately. No partial update survives.
- Timer never exceeds DWELL_CYCLES-1, so no wrap.

Test Plan:
1. Reset release, DWELL_CYCLES=8, src_valid=4'b0101, src_data word0=64'h1111..., word2=64'h2222... -> edge after release:
   - src_ack=0001, disp_src=0, disp_data=word0;
   - 8 cycles later: src_ack=0100, disp_update=1, disp_src=2, disp_data=word2;
   - 8 cycles later: back to 0.
2. Only src_valid[1]=1 and word1 changes every cycle -> disp_data tracks word1 with 1-cycle latency. At each expiry: no src_ack, no disp_update, disp_src stays 1.
3. Showing 0, src_valid drops to 0000 mid-dwell -> disp_data frozen at the last word0 value. State goes IDLE at expiry. disp_data still holds. Reasserting src_valid[3] -> grant 3, src_ack=1000.
4. force_en=1, force_sel=3 while showing 0 with src_valid[3]=0 -> next edge:
   - disp_src=3, disp_update pulse, no src_ack;
   - disp_data=word3 live;
   - timer stays 0 for 20 cycles.
   On release with src_valid=0001: 3 is invalid, so grant 0 immediately, src_ack=0001.
5. Force asserted on the exact cycle of dwell expiry -> FORCE entered, no RR grant, no src_ack.
6. rst pulled low mid-dwell, asynchronously between edges -> all outputs 0 without a clock edge. After release, source 0 is granted first again.
